pinmux_cfg_seq: RTL

Boot-time and on-demand configuration sequencer for the pin-mux control registers on the peripheral bus. It walks an external table of (address, data) entries, issues one bus write per entry, and optionally reads each word back and compares it, retrying on mismatch. It acts as a secondary peripheral-bus master behind a request/grant handshake shared with the CPU, and reports done/error status with the failing entry index.

---
 rtl/pinmux_pkg.sv | 35 +++
 rtl/pinmux_cfg_seq_if.sv | 21 ++
 rtl/pinmux_cfg_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pinmux_pkg.sv
// rtl/pinmux_pkg.sv - shared types and constants for the pin-mux configuration sequencer
package pinmux_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ARB     = 4'd1,
      ST_WRITE   = 4'd2,
      ST_RD_REQ  = 4'd3,
      ST_RD_WAIT = 4'd4,
      ST_CHECK   = 4'd5,
      ST_NEXT    = 4'd6,
      ST_DONE    = 4'd7,
      ST_ERR     = 4'd8
   } seq_state_t;

   typedef enum logic [1:0] {
      FUNC0 = 2'd0,
      FUNC1 = 2'd1,
      FUNC2 = 2'd2,
      FUNC3 = 2'd3
   } pin_func_t;

   // Each control word holds 16 pins at 2 bits; pins 16-31 live at address|1.
   localparam int FUNC_W        = 2;
   localparam int PINS_PER_WORD = 16;

   function automatic logic [31:0] pin_field(input logic [3:0] pin, input pin_func_t func);
      return {30'd0, func} << {pin, 1'b0};
   endfunction

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic high_half);
      return high_half ? (base | 32'd1) : (base & ~32'd1);
   endfunction

endpackage

// File: rtl/pinmux_cfg_seq_if.sv
// rtl/pinmux_cfg_seq_if.sv - peripheral-bus request/grant and strobe signals of the sequencer
interface pinmux_cfg_seq_if;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] sys_w_addr;
   logic [31:0] sys_w_line;
   logic        sys_w;
   logic [31:0] sys_r_addr;
   logic        sys_r;
   logic [31:0] sys_r_line;

   modport master (
      output bus_req, sys_w_addr, sys_w_line, sys_w, sys_r_addr, sys_r,
      input  bus_gnt, sys_r_line
   );

   modport slave (
      input  bus_req, sys_w_addr, sys_w_line, sys_w, sys_r_addr, sys_r,
      output bus_gnt, sys_r_line
   );
endinterface

// File: rtl/pinmux_cfg_seq.sv
// rtl/pinmux_cfg_seq.sv - table-driven pin-mux register writer with optional read-back verify and retry
module pinmux_cfg_seq
   import pinmux_pkg::*;
#(
   parameter int IDX_W     = 4,
   parameter bit VERIFY    = 1'b1,
   parameter int MAX_RETRY = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [IDX_W:0]       tbl_count,
   output logic [IDX_W-1:0]     tbl_idx,
   input  logic [31:0]          tbl_addr,
   input  logic [31:0]          tbl_data,
   pinmux_cfg_seq_if.master     bus,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [IDX_W-1:0]     err_idx
);

   localparam int RTRY_W = $clog2(MAX_RETRY + 2);
   localparam logic [RTRY_W-1:0] RETRY_LIMIT = RTRY_W'(MAX_RETRY);

   seq_state_t        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W:0]    count_q, count_d;
   logic [RTRY_W-1:0] retry_q, retry_d;
   logic              bus_req_q, bus_req_d;
   logic              sys_w_q, sys_w_d;
   logic              sys_r_q, sys_r_d;
   logic [31:0]       w_addr_q, w_addr_d;
   logic [31:0]       w_line_q, w_line_d;
   logic [31:0]       r_addr_q, r_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [IDX_W-1:0]  err_idx_q, err_idx_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         count_q   <= '0;
         retry_q   <= '0;
         bus_req_q <= 1'b0;
         sys_w_q   <= 1'b0;
         sys_r_q   <= 1'b0;
         w_addr_q  <= '0;
         w_line_q  <= '0;
         r_addr_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         count_q   <= count_d;
         retry_q   <= retry_d;
         bus_req_q <= bus_req_d;
         sys_w_q   <= sys_w_d;
         sys_r_q   <= sys_r_d;
         w_addr_q  <= w_addr_d;
         w_line_q  <= w_line_d;
         r_addr_q  <= r_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         err_idx_q <= err_idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      count_d   = count_q;
      retry_d   = retry_q;
      bus_req_d = bus_req_q;
      sys_w_d   = 1'b0;
      sys_r_d   = 1'b0;
      w_addr_d  = w_addr_q;
      w_line_d  = w_line_q;
      r_addr_d  = r_addr_q;
      busy_d    = busy_q;
      done_d    = done_q;
      error_d   = error_q;
      err_idx_d = err_idx_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               done_d    = 1'b0;
               error_d   = 1'b0;
               err_idx_d = '0;
               count_d   = tbl_count;
               idx_d     = '0;
               retry_d   = '0;
               if (tbl_count == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = ST_ARB;
                  busy_d    = 1'b1;
                  bus_req_d = 1'b1;
               end
            end
         end
         ST_ARB: begin
            if (abort) begin
               state_d   = ST_ERR;
               error_d   = 1'b1;
               err_idx_d = idx_q;
               busy_d    = 1'b0;
               bus_req_d = 1'b0;
            end else if (bus.bus_gnt) begin
               state_d  = ST_WRITE;
               sys_w_d  = 1'b1;
               w_addr_d = tbl_addr;
               w_line_d = tbl_data;
            end
         end
         ST_WRITE: begin
            state_d = VERIFY ? ST_RD_REQ : ST_NEXT;
         end
         ST_RD_REQ: begin
            if (abort) begin
               state_d   = ST_ERR;
               error_d   = 1'b1;
               err_idx_d = idx_q;
               busy_d    = 1'b0;
               bus_req_d = 1'b0;
            end else if (bus.bus_gnt) begin
               state_d  = ST_RD_WAIT;
               sys_r_d  = 1'b1;
               r_addr_d = w_addr_q;
            end
         end
         ST_RD_WAIT: begin
            state_d = ST_CHECK;
         end
         // The slave answers one cycle after the strobe it sees, i.e. during CHECK.
         ST_CHECK: begin
            if (bus.sys_r_line == w_line_q) begin
               state_d = ST_NEXT;
            end else if (retry_q < RETRY_LIMIT) begin
               retry_d = retry_q + 1'b1;
               state_d = ST_ARB;
            end else begin
               state_d   = ST_ERR;
               error_d   = 1'b1;
               err_idx_d = idx_q;
               busy_d    = 1'b0;
               bus_req_d = 1'b0;
            end
         end
         ST_NEXT: begin
            retry_d = '0;
            if ({1'b0, idx_q} == count_q - 1'b1) begin
               state_d   = ST_DONE;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               bus_req_d = 1'b0;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_ARB;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tbl_idx        = idx_q;
   assign bus.bus_req    = bus_req_q;
   assign bus.sys_w      = sys_w_q;
   assign bus.sys_w_addr = w_addr_q;
   assign bus.sys_w_line = w_line_q;
   assign bus.sys_r      = sys_r_q;
   assign bus.sys_r_addr = r_addr_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_idx        = err_idx_q;

endmodule
